// File: rtl/ddr3_pkg.sv
// Shared types, command codes and parameter defaults for the DDR3 read/write controller.
package ddr3_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned BEAT_W = 7;
  localparam int unsigned CMD_W  = 3;

  localparam int unsigned BURST_LEN_DEF   = 64;
  localparam int unsigned ADDR_W_DEF      = 28;
  localparam int unsigned WR_BASE_DEF     = 0;
  localparam int unsigned RD_BASE_DEF     = 0;
  localparam int unsigned FRAME_WORDS_DEF = 115200;
  localparam int unsigned RFIFO_TH_DEF    = 512;

  localparam logic [CMD_W-1:0] CMD_WR = 3'b000;
  localparam logic [CMD_W-1:0] CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_WRITE,
    ST_READ
  } state_t;

endpackage

// File: rtl/ddr3_load_sync.sv
// Two-flop synchroniser for an asynchronous frame-sync input, followed by a registered rising-edge pulse.
module ddr3_load_sync
  import ddr3_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic rise
);

  logic [2:0] sync;

  // sync[1:0] is the metastability chain; sync[2] is the previous synchronised value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 3'b000;
      rise <= 1'b0;
    end else begin
      sync <= {sync[1:0], load};
      rise <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/ddr3_rw_ctrl.sv
// Arbitrates fixed-length write bursts (wfifo -> DDR3) and read bursts (DDR3 -> rfifo) over the MIG user interface.
module ddr3_rw_ctrl
  import ddr3_pkg::*;
#(
  parameter int unsigned BURST_LEN   = BURST_LEN_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned WR_BASE     = WR_BASE_DEF,
  parameter int unsigned RD_BASE     = RD_BASE_DEF,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int unsigned RFIFO_TH    = RFIFO_TH_DEF
) (
  input  logic              clk_100,
  input  logic              rst_h,
  input  logic              init_calib_complete,
  input  logic [CNT_W-1:0]  wfifo_rcount,
  input  logic [DATA_W-1:0] wfifo_dout,
  output logic              wfifo_rden,
  input  logic [CNT_W-1:0]  rfifo_wcount,
  output logic [DATA_W-1:0] rfifo_din,
  output logic              rfifo_wren,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic              app_rdy,
  output logic              app_en,
  output logic [CMD_W-1:0]  app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_wdf_rdy,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [DATA_W-1:0] app_wdf_data,
  input  logic              app_rd_data_valid,
  input  logic [DATA_W-1:0] app_rd_data
);

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(8);
  localparam logic [ADDR_W-1:0] WR_START  = ADDR_W'(WR_BASE);
  localparam logic [ADDR_W-1:0] WR_WRAP   = ADDR_W'(WR_BASE + FRAME_WORDS * 8);
  localparam logic [ADDR_W-1:0] RD_START  = ADDR_W'(RD_BASE);
  localparam logic [ADDR_W-1:0] RD_WRAP   = ADDR_W'(RD_BASE + FRAME_WORDS * 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  WR_TH     = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  RD_TH     = CNT_W'(RFIFO_TH);

  state_t            state;
  state_t            next_state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr_inc;
  logic [ADDR_W-1:0] rd_addr_inc;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic              wr_pend;
  logic              rd_pend;
  logic              wr_edge;
  logic              rd_edge;
  logic              wr_issue;
  logic              rd_issue;
  logic              burst_end;
  logic              arb_or_idle;

  ddr3_load_sync u_wr_sync (
    .clk  (clk_100),
    .rst  (rst_h),
    .load (wr_load),
    .rise (wr_edge)
  );

  ddr3_load_sync u_rd_sync (
    .clk  (clk_100),
    .rst  (rst_h),
    .load (rd_load),
    .rise (rd_edge)
  );

  // Write data is taken straight from the show-ahead FIFO head
  assign app_wdf_data = wfifo_dout;

  // Frame-relative address increment with wrap back to the frame base
  assign wr_addr_inc = wr_addr + ADDR_STEP;
  assign rd_addr_inc = rd_addr + ADDR_STEP;
  assign wr_addr_nxt = (wr_addr_inc == WR_WRAP) ? WR_START : wr_addr_inc;
  assign rd_addr_nxt = (rd_addr_inc == RD_WRAP) ? RD_START : rd_addr_inc;
  assign arb_or_idle = (state == ST_IDLE) || (state == ST_ARB);

  // State register; reset drops the FSM to IDLE, which gates every command output low at once
  always_ff @(posedge clk_100 or posedge rst_h) begin
    if (rst_h) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and command handshake; beats only issue when the MIG accepts them this cycle
  always_comb begin
    next_state   = state;
    app_en       = 1'b0;
    app_cmd      = CMD_WR;
    app_addr     = '0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    wfifo_rden   = 1'b0;
    wr_issue     = 1'b0;
    rd_issue     = 1'b0;
    burst_end    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init_calib_complete) begin
          next_state = ST_ARB;
        end
      end
      ST_ARB: begin
        if (!init_calib_complete) begin
          next_state = ST_IDLE;
        end else if (wfifo_rcount >= WR_TH) begin
          next_state = ST_WRITE;
        end else if (rfifo_wcount < RD_TH) begin
          next_state = ST_READ;
        end
      end
      ST_WRITE: begin
        app_addr = wr_addr;
        if (app_rdy && app_wdf_rdy) begin
          wr_issue     = 1'b1;
          app_en       = 1'b1;
          app_wdf_wren = 1'b1;
          app_wdf_end  = 1'b1;
          wfifo_rden   = 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            burst_end  = 1'b1;
            next_state = init_calib_complete ? ST_ARB : ST_IDLE;
          end
        end
      end
      ST_READ: begin
        app_cmd  = CMD_RD;
        app_addr = rd_addr;
        if (app_rdy) begin
          rd_issue = 1'b1;
          app_en   = 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            burst_end  = 1'b1;
            next_state = init_calib_complete ? ST_ARB : ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Beats issued within the current burst
  always_ff @(posedge clk_100 or posedge rst_h) begin
    if (rst_h) begin
      beat_cnt <= '0;
    end else if (burst_end || arb_or_idle) begin
      beat_cnt <= '0;
    end else if (wr_issue || rd_issue) begin
      beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end

  // Write address: frame sync rewinds now when idle, otherwise once the running burst has finished
  always_ff @(posedge clk_100 or posedge rst_h) begin
    if (rst_h) begin
      wr_addr <= WR_START;
      wr_pend <= 1'b0;
    end else if (arb_or_idle) begin
      if (wr_edge || wr_pend) begin
        wr_addr <= WR_START;
      end
      wr_pend <= 1'b0;
    end else if (burst_end && (wr_edge || wr_pend)) begin
      wr_addr <= WR_START;
      wr_pend <= 1'b0;
    end else begin
      if (wr_issue) begin
        wr_addr <= wr_addr_nxt;
      end
      if (wr_edge) begin
        wr_pend <= 1'b1;
      end
    end
  end

  // Read address: same rewind rule as the write side
  always_ff @(posedge clk_100 or posedge rst_h) begin
    if (rst_h) begin
      rd_addr <= RD_START;
      rd_pend <= 1'b0;
    end else if (arb_or_idle) begin
      if (rd_edge || rd_pend) begin
        rd_addr <= RD_START;
      end
      rd_pend <= 1'b0;
    end else if (burst_end && (rd_edge || rd_pend)) begin
      rd_addr <= RD_START;
      rd_pend <= 1'b0;
    end else begin
      if (rd_issue) begin
        rd_addr <= rd_addr_nxt;
      end
      if (rd_edge) begin
        rd_pend <= 1'b1;
      end
    end
  end

  // Returned read data is forwarded to the read FIFO one cycle later, independent of FSM state
  always_ff @(posedge clk_100 or posedge rst_h) begin
    if (rst_h) begin
      rfifo_wren <= 1'b0;
      rfifo_din  <= '0;
    end else begin
      rfifo_wren <= app_rd_data_valid;
      rfifo_din  <= app_rd_data;
    end
  end

endmodule

// File: tb/tb_ddr3_rw_ctrl.sv
// Directed bench for ddr3_rw_ctrl with a 128-word frame so address wrap is reachable.
module tb_ddr3_rw_ctrl;

  localparam int unsigned AW   = 28;
  localparam int unsigned WRAP = 1024;

  logic         clk_100 = 1'b0;
  logic         rst_h;
  logic         init_calib_complete;
  logic [10:0]  wfifo_rcount;
  logic [127:0] wfifo_dout;
  logic         wfifo_rden;
  logic [10:0]  rfifo_wcount;
  logic [127:0] rfifo_din;
  logic         rfifo_wren;
  logic         wr_load;
  logic         rd_load;
  logic         app_rdy;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [AW-1:0] app_addr;
  logic         app_wdf_rdy;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [127:0] app_wdf_data;
  logic         app_rd_data_valid;
  logic [127:0] app_rd_data;

  int checks = 0;
  int errors = 0;

  ddr3_rw_ctrl #(
    .BURST_LEN   (64),
    .ADDR_W      (AW),
    .WR_BASE     (0),
    .RD_BASE     (0),
    .FRAME_WORDS (128),
    .RFIFO_TH    (512)
  ) dut (
    .clk_100             (clk_100),
    .rst_h               (rst_h),
    .init_calib_complete (init_calib_complete),
    .wfifo_rcount        (wfifo_rcount),
    .wfifo_dout          (wfifo_dout),
    .wfifo_rden          (wfifo_rden),
    .rfifo_wcount        (rfifo_wcount),
    .rfifo_din           (rfifo_din),
    .rfifo_wren          (rfifo_wren),
    .wr_load             (wr_load),
    .rd_load             (rd_load),
    .app_rdy             (app_rdy),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_data        (app_wdf_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data         (app_rd_data)
  );

  always #5 clk_100 = ~clk_100;

  // Drives one write burst and tallies what the DUT did against the expected address sequence
  task automatic run_write(input logic [AW-1:0] start, input bit stall, input int load_at,
                           input int drop_at, output int beats, output int bad_addr,
                           output int bad_ctl, output int rden_cnt, output int gap);
    int cyc;
    bit started;
    logic [AW-1:0] exp;
    beats = 0; bad_addr = 0; bad_ctl = 0; rden_cnt = 0; gap = 0; cyc = 0; started = 1'b0;
    wfifo_rcount = 11'd64;
    app_rdy = 1'b1;
    while (beats < 64 && cyc < 400) begin
      @(negedge clk_100);
      cyc++;
      app_wdf_rdy = stall ? cyc[0] : 1'b1;
      wfifo_dout = {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (!app_wdf_rdy && wfifo_rden) bad_ctl++;
      if (wfifo_rden) rden_cnt++;
      if (app_en) begin
        exp = AW'((32'(start) + 32'(8 * beats)) % WRAP);
        if (app_addr !== exp) bad_addr++;
        if (app_cmd !== 3'b000 || !app_wdf_wren || !app_wdf_end || !wfifo_rden ||
            app_wdf_data !== wfifo_dout) bad_ctl++;
        started = 1'b1;
        beats++;
        if (beats - 1 == load_at) wr_load = 1'b1;
        if (beats - 1 == load_at + 2) wr_load = 1'b0;
        if (beats - 1 == drop_at) init_calib_complete = 1'b0;
      end else begin
        if (app_wdf_wren || app_wdf_end || wfifo_rden) bad_ctl++;
        if (started && app_rdy && app_wdf_rdy) gap++;
      end
    end
    wfifo_rcount = 11'd0;
    wr_load = 1'b0;
    app_wdf_rdy = 1'b1;
    repeat (4) begin
      @(negedge clk_100);
      #1;
      if (app_en) beats++;
    end
  endtask

  // Drives one read burst while streaming random read returns and tracking the 1-cycle forward
  task automatic run_read(input logic [AW-1:0] start, output int cmds, output int bad_addr,
                          output int bad_ctl, output int bad_rd, output int gap);
    int cyc;
    bit started;
    logic prev_v;
    logic [127:0] prev_d;
    logic [AW-1:0] exp;
    cmds = 0; bad_addr = 0; bad_ctl = 0; bad_rd = 0; gap = 0; cyc = 0; started = 1'b0;
    prev_v = app_rd_data_valid;
    prev_d = app_rd_data;
    wfifo_rcount = 11'd0;
    rfifo_wcount = 11'd100;
    app_rdy = 1'b1;
    while (cmds < 64 && cyc < 400) begin
      @(negedge clk_100);
      cyc++;
      #1;
      if (rfifo_wren !== prev_v || (prev_v && rfifo_din !== prev_d)) bad_rd++;
      app_rd_data_valid = 1'($urandom % 2);
      app_rd_data = {$urandom, $urandom, $urandom, $urandom};
      prev_v = app_rd_data_valid;
      prev_d = app_rd_data;
      if (app_en) begin
        exp = AW'((32'(start) + 32'(8 * cmds)) % WRAP);
        if (app_addr !== exp) bad_addr++;
        if (app_cmd !== 3'b001 || wfifo_rden || app_wdf_wren) bad_ctl++;
        started = 1'b1;
        cmds++;
      end else if (started) begin
        gap++;
      end
    end
    rfifo_wcount = 11'd1000;
    @(negedge clk_100);
    #1;
    if (rfifo_wren !== prev_v || (prev_v && rfifo_din !== prev_d)) bad_rd++;
    if (app_en) cmds++;
    app_rd_data_valid = 1'b0;
    repeat (3) begin
      @(negedge clk_100);
      #1;
      if (app_en) cmds++;
    end
  endtask

  task automatic test_reset();
    int en_cnt;
    rst_h = 1'b1;
    init_calib_complete = 1'b0;
    wfifo_rcount = 11'd64;
    rfifo_wcount = 11'd1000;
    wfifo_dout = '0;
    wr_load = 1'b0; rd_load = 1'b0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data_valid = 1'b0; app_rd_data = '0;
    repeat (3) @(negedge clk_100);
    #1;
    checks++;
    if ({app_en, app_wdf_wren, app_wdf_end, wfifo_rden, rfifo_wren} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b expected 00000",
               {app_en, app_wdf_wren, app_wdf_end, wfifo_rden, rfifo_wren});
    end
    checks++;
    if (app_addr !== '0 || app_cmd !== 3'b000 || rfifo_din !== '0) begin
      errors++;
      $display("FAIL reset_bus got addr=%0d cmd=%0d expected 0 0", app_addr, app_cmd);
    end
    rst_h = 1'b0;
    en_cnt = 0;
    repeat (6) begin
      @(negedge clk_100);
      #1;
      if (app_en) en_cnt++;
    end
    checks++;
    if (en_cnt != 0) begin
      errors++;
      $display("FAIL idle_no_calib got %0d commands expected 0", en_cnt);
    end
    wfifo_rcount = 11'd0;
    init_calib_complete = 1'b1;
    repeat (2) @(negedge clk_100);
  endtask

  task automatic test_write_burst();
    int beats, bad_addr, bad_ctl, rden_cnt, gap;
    run_write(AW'(0), 1'b0, -1, -1, beats, bad_addr, bad_ctl, rden_cnt, gap);
    checks++;
    if (beats != 64) begin errors++; $display("FAIL wr_beats got %0d expected 64", beats); end
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL wr_addr got %0d bad expected 0", bad_addr); end
    checks++;
    if (bad_ctl != 0) begin errors++; $display("FAIL wr_ctl got %0d bad expected 0", bad_ctl); end
    checks++;
    if (rden_cnt != 64) begin errors++; $display("FAIL wr_rden got %0d expected 64", rden_cnt); end
    checks++;
    if (gap != 0) begin errors++; $display("FAIL wr_consecutive got %0d gaps expected 0", gap); end
  endtask

  task automatic test_backpressure();
    int beats, bad_addr, bad_ctl, rden_cnt, gap;
    run_write(AW'(512), 1'b1, -1, -1, beats, bad_addr, bad_ctl, rden_cnt, gap);
    checks++;
    if (beats != 64) begin errors++; $display("FAIL bp_beats got %0d expected 64", beats); end
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL bp_addr got %0d bad expected 0", bad_addr); end
    checks++;
    if (bad_ctl != 0) begin errors++; $display("FAIL bp_ctl got %0d bad expected 0", bad_ctl); end
    checks++;
    if (rden_cnt != 64) begin errors++; $display("FAIL bp_rden got %0d expected 64", rden_cnt); end
    checks++;
    if (gap != 0) begin errors++; $display("FAIL bp_gap got %0d expected 0", gap); end
  endtask

  task automatic test_wrap();
    int beats, bad_addr, bad_ctl, rden_cnt, gap;
    run_write(AW'(0), 1'b0, -1, -1, beats, bad_addr, bad_ctl, rden_cnt, gap);
    checks++;
    if (beats != 64) begin errors++; $display("FAIL wrap_beats got %0d expected 64", beats); end
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL wrap_addr got %0d bad expected 0", bad_addr); end
  endtask

  task automatic test_read_burst();
    int cmds, bad_addr, bad_ctl, bad_rd, gap;
    run_read(AW'(0), cmds, bad_addr, bad_ctl, bad_rd, gap);
    checks++;
    if (cmds != 64) begin errors++; $display("FAIL rd_cmds got %0d expected 64", cmds); end
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL rd_addr got %0d bad expected 0", bad_addr); end
    checks++;
    if (bad_ctl != 0) begin errors++; $display("FAIL rd_ctl got %0d bad expected 0", bad_ctl); end
    checks++;
    if (bad_rd != 0) begin errors++; $display("FAIL rd_forward got %0d bad expected 0", bad_rd); end
    checks++;
    if (gap != 0) begin errors++; $display("FAIL rd_gap got %0d expected 0", gap); end
  endtask

  task automatic test_read_load_idle();
    int cmds, bad_addr, bad_ctl, bad_rd, gap;
    @(negedge clk_100);
    rd_load = 1'b1;
    repeat (2) @(negedge clk_100);
    rd_load = 1'b0;
    repeat (6) @(negedge clk_100);
    run_read(AW'(0), cmds, bad_addr, bad_ctl, bad_rd, gap);
    checks++;
    if (cmds != 64) begin errors++; $display("FAIL rdload_cmds got %0d expected 64", cmds); end
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL rdload_addr got %0d bad expected 0", bad_addr); end
  endtask

  task automatic test_load_mid_burst(input int load_at, input logic [AW-1:0] start);
    int beats, bad_addr, bad_ctl, rden_cnt, gap;
    run_write(start, 1'b0, load_at, -1, beats, bad_addr, bad_ctl, rden_cnt, gap);
    checks++;
    if (beats != 64) begin errors++; $display("FAIL load%0d_beats got %0d expected 64", load_at, beats); end
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL load%0d_own_addr got %0d bad expected 0", load_at, bad_addr); end
    run_write(AW'(0), 1'b0, -1, -1, beats, bad_addr, bad_ctl, rden_cnt, gap);
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL load%0d_rewind got %0d bad expected 0", load_at, bad_addr); end
  endtask

  task automatic test_calib_drop();
    int beats, bad_addr, bad_ctl, rden_cnt, gap, en_cnt;
    run_write(AW'(512), 1'b0, -1, 20, beats, bad_addr, bad_ctl, rden_cnt, gap);
    checks++;
    if (beats != 64) begin errors++; $display("FAIL drop_beats got %0d expected 64", beats); end
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL drop_addr got %0d bad expected 0", bad_addr); end
    wfifo_rcount = 11'd64;
    en_cnt = 0;
    repeat (10) begin
      @(negedge clk_100);
      #1;
      if (app_en) en_cnt++;
    end
    checks++;
    if (en_cnt != 0) begin errors++; $display("FAIL drop_idle got %0d commands expected 0", en_cnt); end
    init_calib_complete = 1'b1;
    run_write(AW'(0), 1'b0, -1, -1, beats, bad_addr, bad_ctl, rden_cnt, gap);
    checks++;
    if (beats != 64 || bad_addr != 0) begin
      errors++;
      $display("FAIL drop_resume got beats=%0d bad=%0d expected 64 0", beats, bad_addr);
    end
  endtask

  task automatic test_reset_mid_burst();
    int beats, cyc, bad_addr, bad_ctl, rden_cnt, gap, en_cnt;
    beats = 0;
    cyc = 0;
    wfifo_rcount = 11'd64;
    app_rdy = 1'b1;
    app_wdf_rdy = 1'b1;
    app_rd_data_valid = 1'b1;
    app_rd_data = {4{32'hA5A5_0F0F}};
    while (beats < 10 && cyc < 200) begin
      @(negedge clk_100);
      cyc++;
      #1;
      if (app_en) beats++;
    end
    @(negedge clk_100);
    #1;
    checks++;
    if (!app_en || !rfifo_wren || app_addr !== AW'(512 + 80)) begin
      errors++;
      $display("FAIL rstmid_beat10 got en=%0d wren=%0d addr=%0d expected 1 1 592", app_en, rfifo_wren, app_addr);
    end
    rst_h = 1'b1;
    #1;
    checks++;
    if ({app_en, app_wdf_wren, app_wdf_end, wfifo_rden, rfifo_wren} !== 5'b0) begin
      errors++;
      $display("FAIL rstmid_ctl got %b expected 00000",
               {app_en, app_wdf_wren, app_wdf_end, wfifo_rden, rfifo_wren});
    end
    checks++;
    if (app_addr !== '0 || rfifo_din !== '0) begin
      errors++;
      $display("FAIL rstmid_bus got addr=%0d expected 0", app_addr);
    end
    app_rd_data_valid = 1'b0;
    en_cnt = 0;
    repeat (3) begin
      @(negedge clk_100);
      #1;
      if (app_en) en_cnt++;
    end
    rst_h = 1'b0;
    #1;
    if (app_en) en_cnt++;
    checks++;
    if (en_cnt != 0) begin errors++; $display("FAIL rstmid_hold got %0d commands expected 0", en_cnt); end
    run_write(AW'(0), 1'b0, -1, -1, beats, bad_addr, bad_ctl, rden_cnt, gap);
    checks++;
    if (beats != 64 || bad_addr != 0) begin
      errors++;
      $display("FAIL rstmid_restart got beats=%0d bad=%0d expected 64 0", beats, bad_addr);
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_backpressure();
    test_wrap();
    test_read_burst();
    test_read_load_idle();
    test_load_mid_burst(10, AW'(512));
    test_load_mid_burst(60, AW'(512));
    test_calib_drop();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
